// File: rtl/qupls_ins_queue_pkg.sv
// Shared Qupls front-end types: instruction word, PC, decoder NOP and queue entry payload.
package QuplsPkg;

  localparam int unsigned INSN_W = 40;
  localparam int unsigned PC_W   = 32;

  typedef logic [INSN_W-1:0] instruction_t;
  typedef logic [PC_W-1:0]   pc_address_t;

  localparam instruction_t QUPLS_NOP_INSN = 40'h00_0000_00FF;

  typedef struct packed {
    instruction_t ins;
    pc_address_t  pc;
  } insq_entry_t;

endpackage

// File: rtl/qupls_ins_queue_rdwin.sv
// Decode window read: WIN modulo-indexed reads from head, NOP fill and valid mask for slots beyond cnt.
module qupls_ins_queue_rdwin
  import QuplsPkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIN   = 6
) (
  input  insq_entry_t                        mem_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]           head_i,
  input  logic [$clog2(DEPTH+1)-1:0]         cnt_i,
  output logic [WIN-1:0][INSN_W-1:0]         ins_o,
  output logic [PC_W-1:0]                    pc_o,
  output logic [WIN-1:0]                     vmask_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [IDX_W-1:0] idx;

  always_comb begin
    ins_o   = '0;
    vmask_o = '0;
    idx     = '0;
    for (int i = 0; i < WIN; i++) begin
      idx        = IDX_W'(head_i + IDX_W'(i));
      vmask_o[i] = (CNT_W'(i) < cnt_i);
      ins_o[i]   = vmask_o[i] ? mem_i[idx].ins : QUPLS_NOP_INSN;
    end
    pc_o = vmask_o[0] ? mem_i[head_i].pc : '0;
  end

endmodule

// File: rtl/qupls_ins_queue.sv
// Instruction queue between fetch/align and the decoder: circular buffer with a WIN-slot decode window.
// Optional same-cycle fetch-to-window bypass on an empty queue: define QUPLS_INSQ_BYPASS_EN.
module qupls_ins_queue
  import QuplsPkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned FETCH_W = 4,
  parameter int unsigned WIN     = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               fet_v,
  input  logic [2:0]                         fet_cnt,
  input  logic [FETCH_W-1:0][INSN_W-1:0]     fet_ins,
  input  logic [FETCH_W-1:0][PC_W-1:0]       fet_pc,
  output logic                               fet_rdy,
  input  logic                               en,
  input  logic [2:0]                         adv,
  output logic [WIN-1:0][INSN_W-1:0]         win_ins,
  output logic [PC_W-1:0]                    win_pc,
  output logic [WIN-1:0]                     win_vmask,
  output logic                               win_v,
  output logic [$clog2(DEPTH+1)-1:0]         cnt,
  output logic                               adv_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  insq_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv_err_q, adv_err_d;

  logic             push_ok;
  logic             pop_req;
  logic             bypass_act;
  logic             adv_big;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] popped;

  logic [WIN-1:0][INSN_W-1:0] rd_ins;
  logic [PC_W-1:0]            rd_pc;
  logic [WIN-1:0]             rd_vmask;

  assign fet_rdy = (cnt_q <= CNT_W'(DEPTH - FETCH_W));
  assign push_ok = fet_v && fet_rdy && !flush;
  assign pop_req = en && (adv != 3'd0) && !flush;

`ifdef QUPLS_INSQ_BYPASS_EN
  assign bypass_act = push_ok && (cnt_q == '0) && (fet_cnt != 3'd0);
`else
  assign bypass_act = 1'b0;
`endif

  // Occupancy bookkeeping; bypassed slots count as available for this cycle's advance.
  always_comb begin
    push_n    = '0;
    popped    = '0;
    adv_err_d = 1'b0;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    if (push_ok)
      push_n = (fet_cnt > 3'(FETCH_W)) ? CNT_W'(FETCH_W) : CNT_W'(fet_cnt);
    avail   = cnt_q + (bypass_act ? push_n : '0);
    adv_big = (CNT_W'(adv) > avail);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (pop_req) begin
        popped    = adv_big ? avail : CNT_W'(adv);
        adv_err_d = adv_big;
      end
      head_d = head_q + PTR_W'(popped);
      tail_d = tail_q + PTR_W'(push_n);
      cnt_d  = cnt_q + push_n - popped;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      adv_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      adv_err_q <= adv_err_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by head/cnt.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (rst_n && push_ok && (CNT_W'(i) < push_n))
        mem_q[IDX_W'(tail_q + PTR_W'(i))] <= '{ins: fet_ins[i], pc: fet_pc[i]};
    end
  end

  qupls_ins_queue_rdwin #(
    .DEPTH (DEPTH),
    .WIN   (WIN)
  ) u_rdwin (
    .mem_i   (mem_q),
    .head_i  (head_q[IDX_W-1:0]),
    .cnt_i   (cnt_q),
    .ins_o   (rd_ins),
    .pc_o    (rd_pc),
    .vmask_o (rd_vmask)
  );

  always_comb begin
    win_ins   = rd_ins;
    win_pc    = rd_pc;
    win_vmask = rd_vmask;
`ifdef QUPLS_INSQ_BYPASS_EN
    if (bypass_act) begin
      win_pc    = fet_pc[0];
      win_ins   = {WIN{QUPLS_NOP_INSN}};
      win_vmask = '0;
      for (int i = 0; i < FETCH_W; i++) begin
        if (CNT_W'(i) < push_n) begin
          win_ins[i]   = fet_ins[i];
          win_vmask[i] = 1'b1;
        end
      end
    end
`endif
  end

  assign win_v   = win_vmask[0];
  assign cnt     = cnt_q;
  assign adv_err = adv_err_q;

endmodule

// File: doc/qupls_ins_queue.md
# qupls_ins_queue

Instruction queue sitting between the fetch/align stage and `Qupls_decoder`. It buffers fetched instruction groups and presents the decoder with a six-slot window (current instruction plus five following slots for immediate postfixes). The decode stage reports how many slots it consumed (1 + postfixes) and the queue advances its head by that amount. Flush empties the queue in one cycle for branch mispredicts and exceptions.

## Interface
- `DEPTH`, 16: queue entries; power of two, ≥ 2·FETCH_W.
- `FETCH_W`, 4: maximum instructions pushed per cycle.
- `WIN`, 6: window slots presented to decode.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush` in 1: discard all entries.
- `fet_v` in 1: fetch group valid.
- `fet_cnt` in 3: valid instructions in group, 1..FETCH_W, lowest slots first.
- `fet_ins` in FETCH_W × instruction_t: fetched instructions.
- `fet_pc` in FETCH_W × pc_address_t: per-instruction PC.
- `fet_rdy` out 1: room for a full group.
- `en` in 1: decode stage enable; advance honoured only when high.
- `adv` in 3: slots consumed this cycle, 0..WIN.
- `win_ins` out WIN × instruction_t: slots head..head+WIN-1.
- `win_pc` out pc_address_t: PC of slot 0.
- `win_vmask` out WIN: per-slot valid.
- `win_v` out 1: equals `win_vmask[0]`.
- `cnt` out $clog2(DEPTH+1): occupancy.
- `adv_err` out 1: one-cycle pulse on illegal advance.

## Operation
- Storage: DEPTH-entry circular array of {instruction_t, pc_address_t}. Head/tail pointers are log2(DEPTH)+1 bits wide; the extra bit disambiguates full/empty. Indexing is modulo DEPTH.
- Push is accepted when `fet_v && fet_rdy`. It writes `fet_cnt` entries at tail..tail+fet_cnt-1, wrapping.
- `fet_rdy` = (cnt ≤ DEPTH−FETCH_W). It is computed from the registered cnt and ignores any same-cycle pop.
- `fet_v` with `fet_rdy` low: the group is dropped. Fetch must hold the group, and the bench flags this as a protocol violation.
- Pop occurs when `en` is high and `adv` ≠ 0.
  - Legal pop: adv ≤ cnt, and head advances by adv.
  - adv > cnt: head advances by cnt (queue empties) and `adv_err` pulses.
- cnt_next = cnt + pushed − popped. Push and pop in the same cycle are both honoured.
- Window: slot i is valid iff i < cnt.
  - Valid slots drive the stored instruction.
  - Invalid slots drive `QUPLS_NOP_INSN` so the decoder sees a NOP.
  - `win_pc` is 0 when `win_v` is low.
- Flush: head = tail = 0 and cnt = 0. Any same-cycle push and pop are discarded. Flush has priority over everything except reset.
- Reset: same state as flush, and `adv_err` = 0.

## Timing
- Reset values: `cnt`=0, `win_vmask`=0, `win_v`=0, `win_ins`=all `QUPLS_NOP_INSN`, `win_pc`=0, `fet_rdy`=1, `adv_err`=0.
- Window outputs are combinational reads of registered state (head, cnt, array). The decoder registers them on its `en`.
- Push-to-window latency is 1 cycle: an instruction pushed in cycle N is visible in the window in cycle N+1. The exception is the bypass (see Configuration).
- Pop takes effect at the clock edge: the window shifts in the next cycle.
- Wrap-around: a window that straddles index DEPTH−1→0 reads contiguously.
- Reset asserted mid-operation (e.g. cnt=9) clears the queue at the next edge regardless of push, pop or flush.

## Configuration
- `QUPLS_INSQ_BYPASS_EN`
  - Defined: when cnt=0 and a push is accepted, the incoming slots drive the window combinationally in the same cycle.
    - `win_vmask` reflects `fet_cnt`.
    - A same-cycle `adv` ≤ fet_cnt is honoured, and only the remainder is written.
    - Flush suppresses the bypass.
  - Undefined: no bypass, and latency is always 1 cycle.

## Structure
- Shared package `QuplsPkg`: `instruction_t`, `pc_address_t`, and the `QUPLS_NOP_INSN` constant.
- Sub-module `qupls_ins_queue_rdwin`: combinational window read, i.e. WIN modulo-indexed array reads, NOP substitution and valid-mask generation.
- The top level holds the pointers, counter, write logic, flush and bypass.

## Test plan
- Reset then push 4 (PCs 0x100..0x10C), en=1, adv=0 → next cycle cnt=4, vmask=6'b001111, win_pc=0x100, slots 4–5 = NOP.
- Push 4 per cycle with adv=0 → fet_rdy goes low at cnt=16. A fifth group offered with fet_rdy low is dropped and cnt stays 16.
- cnt=10, head at index 13, adv=3 while pushing 4 → cnt=11. Window slot 0 = entry index 0 (wrap), contiguous PCs.
- cnt=2, adv=5 → adv_err pulses for one cycle, cnt=0, win_v=0.
- cnt=8, flush together with push 4 and adv 2 → cnt=0 next cycle, window all NOP.
- With `QUPLS_INSQ_BYPASS_EN` defined: empty queue, push 3 and adv=1 in the same cycle → win_v=1 that cycle, cnt=2 next cycle, slot 0 = the second pushed instruction.
